ev2_phy_router: RTL and testbench
=================================

EV2_PHY_ROUTER -- requirements
Module: ev2_phy_router

Interface
REQ-001 Parameter NUM_PHY, default 2, number of physical event bridges (legal 1-4; index 0 = USB, 1 = PCIe).
REQ-002 Parameter MODE, default "FAILOVER", "FIXED" = use sel_i only, "FAILOVER" = fall back to lowest-index linked PHY.
REQ-003 Parameter DROP_WIDTH, default 16, width of the saturating drop counter.
REQ-004 Port clk_i, input, 1, the single clock (irsclk domain); all logic is rising-edge.
REQ-005 Port rst_n_i, input, 1, reset, asynchronous assert, active-low.
REQ-006 Port src_dat_i, input, 16, event word from the ev2 interface.
REQ-007 Port src_wr_i, input, 1, word strobe.
REQ-008 Port src_last_i, input, 1, qualifies src_wr_i as the final word of an event.
REQ-009 Port src_full_o, output, 1, backpressure to the event source.
REQ-010 Port src_count_o, output, 16, free-word count of the active PHY.
REQ-011 Port src_rst_i / src_rst_ack_o, input/output, 1 each, event-path reset request and acknowledge.
REQ-012 Port sel_i, input, 2, requested PHY index.
REQ-013 Port link_up_i, input, NUM_PHY, per-PHY link-up flag (already synchronised).
REQ-014 Ports phy_dat_o (16*NUM_PHY), phy_wr_o, phy_rst_o (NUM_PHY each), outputs, per-PHY ev2 write side.
REQ-015 Ports phy_full_i, phy_rst_ack_i (NUM_PHY each), phy_count_i (16*NUM_PHY), inputs, per-PHY ev2 status.
REQ-016 Ports active_o (2), frame_cnt_o (32), drop_cnt_o (DROP_WIDTH), outputs, status.

Function
REQ-017 States: IDLE, STREAM, RST_WAIT, RST_DONE.
REQ-018 Active PHY is re-chosen only in IDLE, never mid-event.
REQ-019 FIXED: active = sel_i; FAILOVER: active = sel_i if link_up_i[sel_i], else lowest index with link up; none up -> active unchanged, no_link asserted.
REQ-020 sel_i >= NUM_PHY treated as 0.
REQ-021 IDLE -> STREAM on an accepted src_wr_i with src_last_i low; accepted single-word event (last high) stays in IDLE.
REQ-022 STREAM -> IDLE on accepted or dropped write with src_last_i high.
REQ-023 Word accepted when src_wr_i high and phy_full_i[active] low and not no_link; forwarded to phy_dat_o/phy_wr_o of active PHY with exactly 1-cycle registered latency.
REQ-024 Non-active PHYs: phy_wr_o low, phy_dat_o held.
REQ-025 src_full_o = phy_full_i[active] OR no_link OR state in {RST_WAIT, RST_DONE}, combinational.
REQ-026 src_count_o = phy_count_i[active], or 0 when no_link.
REQ-027 Write while src_full_o high: word dropped, drop_cnt_o += 1, saturating at all-ones.
REQ-028 Link loss on active PHY mid-event: no switch; remaining words follow REQ-023/REQ-027.
REQ-029 frame_cnt_o += 1 per accepted last word, wraps 2^32-1 -> 0; dropped last words not counted.
REQ-030 src_rst_i high in any state -> RST_WAIT next cycle, pending event abandoned, phy_rst_o all bits high.
REQ-031 RST_WAIT -> RST_DONE when phy_rst_ack_i high for every PHY with link up (all PHYs if none up).
REQ-032 RST_DONE: src_rst_ack_o high, phy_rst_o held high; src_rst_i low -> IDLE, phy_rst_o and src_rst_ack_o low next cycle.
REQ-033 Entering RST_DONE clears frame_cnt_o and drop_cnt_o.

Reset
REQ-034 rst_n_i low: state IDLE, active_o 0, all phy_wr_o/phy_rst_o 0, phy_dat_o 0, src_rst_ack_o 0, counters 0, immediately and independent of clk_i.
REQ-035 Release of rst_n_i takes effect on first clk_i edge after deassertion; no words accepted in that cycle.

Verification
REQ-036 FAILOVER, sel_i=1, link_up=2'b01, 4-word event 0xA0..0xA3 -> active_o=0, phy_dat_o[0] 0xA0..0xA3 one cycle late, frame_cnt_o=1.
REQ-037 sel_i changed 0->1 after word 2 of 5-word event -> all 5 on PHY0; next event on PHY1.
REQ-038 phy_full_i[active] high for 3 write cycles -> src_full_o high, 3 words missing downstream, drop_cnt_o=3; DROP_WIDTH=2 with 5 drops -> 3.
REQ-039 src_rst_i mid-event, PHY1 ack 4 cycles after PHY0 -> src_rst_ack_o rises only after both acks; counters 0; state IDLE one cycle after src_rst_i falls.
REQ-040 FIXED, sel_i=1, link_up=0 -> writes dropped, no phy_wr_o; rst_n_i low mid-STREAM -> all outputs 0 without clock edge.

Source files
------------

// File: rtl/ev2_phy_router.sv
`default_nettype none
// ============================================================================
// Module  : ev2_phy_router
// Purpose : Routes a stream of ev2 event words from one source onto one of
//           NUM_PHY physical event bridges (0 = USB, 1 = PCIe). The active
//           bridge is only re-chosen between events, optionally failing over
//           to the lowest-index bridge whose link is up. Words that cannot be
//           delivered are dropped and counted; completed events are counted.
//           A source-initiated event-path reset is fanned out to all bridges
//           and acknowledged once the relevant bridges have acknowledged.
// Ports   : clk_i, rst_n_i            clock, async active-low reset
//           src_dat_i/wr_i/last_i     event word, strobe, end-of-event flag
//           src_full_o, src_count_o   backpressure and free-word count
//           src_rst_i/src_rst_ack_o   event-path reset handshake
//           sel_i, link_up_i          requested bridge, per-bridge link state
//           phy_dat_o/wr_o/rst_o      per-bridge write side
//           phy_full_i/rst_ack_i/count_i  per-bridge status
//           active_o, frame_cnt_o, drop_cnt_o  status
// Revision: 1.0  initial release
// ============================================================================
module ev2_phy_router #(
  parameter int    NUM_PHY    = 2,
  parameter string MODE       = "FAILOVER",
  parameter int    DROP_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [15:0]             src_dat_i,
  input  logic                    src_wr_i,
  input  logic                    src_last_i,
  output logic                    src_full_o,
  output logic [15:0]             src_count_o,
  input  logic                    src_rst_i,
  output logic                    src_rst_ack_o,
  input  logic [1:0]              sel_i,
  input  logic [NUM_PHY-1:0]      link_up_i,
  output logic [16*NUM_PHY-1:0]   phy_dat_o,
  output logic [NUM_PHY-1:0]      phy_wr_o,
  output logic [NUM_PHY-1:0]      phy_rst_o,
  input  logic [NUM_PHY-1:0]      phy_full_i,
  input  logic [NUM_PHY-1:0]      phy_rst_ack_i,
  input  logic [16*NUM_PHY-1:0]   phy_count_i,
  output logic [1:0]              active_o,
  output logic [31:0]             frame_cnt_o,
  output logic [DROP_WIDTH-1:0]   drop_cnt_o
);

  localparam bit         FIXED_MODE = (MODE == "FIXED");
  localparam logic [3:0] PHY_MASK   = 4'((1 << NUM_PHY) - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_STREAM   = 2'd1,
    S_RST_WAIT = 2'd2,
    S_RST_DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              active_q;
  logic                    run_q;
  logic [NUM_PHY-1:0]      phy_wr_q;
  logic [16*NUM_PHY-1:0]   phy_dat_q;
  logic [31:0]             frame_q;
  logic [DROP_WIDTH-1:0]   drop_q;

  // Per-bridge status zero-padded to four entries so a 2-bit index is
  // always in range regardless of NUM_PHY.
  logic [3:0]       link4, full4, ack4;
  logic [3:0][15:0] cnt4;
  logic [1:0]       sel_eff, low_idx, choice, act;
  logic             no_link, in_rst, accept, drop, acks_ok;
  logic [3:0]       ack_mask;

  always_comb begin
    link4 = '0;
    full4 = '0;
    ack4  = '0;
    cnt4  = '0;
    for (int i = 0; i < NUM_PHY; i++) begin
      link4[i] = link_up_i[i];
      full4[i] = phy_full_i[i];
      ack4[i]  = phy_rst_ack_i[i];
      cnt4[i]  = phy_count_i[16*i +: 16];
    end
  end

  // Lowest-index bridge with link up (downward scan so index 0 wins).
  always_comb begin
    low_idx = 2'd0;
    for (int i = NUM_PHY - 1; i >= 0; i--) begin
      if (link4[i]) low_idx = 2'(i);
    end
  end

  assign sel_eff = (int'(sel_i) < NUM_PHY) ? sel_i : 2'd0;
  assign no_link = (link4 == 4'd0);

  always_comb begin
    if (FIXED_MODE)         choice = sel_eff;
    else if (no_link)       choice = active_q;
    else if (link4[sel_eff]) choice = sel_eff;
    else                    choice = low_idx;
  end

  // The selection is only live between events; inside an event the bridge
  // that took the first word keeps the rest, even if its link drops.
  assign act    = (state_q == S_IDLE) ? choice : active_q;
  assign in_rst = (state_q == S_RST_WAIT) || (state_q == S_RST_DONE);

  // run_q holds off acceptance for the first edge after reset release.
  assign src_full_o  = full4[act] | no_link | in_rst | ~run_q;
  assign src_count_o = no_link ? 16'd0 : cnt4[act];
  assign accept      = src_wr_i & ~src_full_o;
  assign drop        = src_wr_i &  src_full_o;

  // With no link anywhere, every bridge must acknowledge the reset.
  assign ack_mask = no_link ? PHY_MASK : link4;
  assign acks_ok  = ((ack4 & ack_mask) == ack_mask);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (src_rst_i)                  state_d = S_RST_WAIT;
        else if (accept && !src_last_i) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (src_rst_i)                  state_d = S_RST_WAIT;
        else if (src_wr_i && src_last_i) state_d = S_IDLE;
      end
      S_RST_WAIT: begin
        if (acks_ok)                    state_d = S_RST_DONE;
      end
      S_RST_DONE: begin
        if (!src_rst_i)                 state_d = S_IDLE;
      end
      default:                          state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      active_q <= 2'd0;
      run_q    <= 1'b0;
      frame_q  <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= act;
      run_q    <= 1'b1;
      if (state_d == S_RST_DONE && state_q != S_RST_DONE) begin
        frame_q <= '0;
        drop_q  <= '0;
      end else begin
        if (accept && src_last_i) frame_q <= frame_q + 32'd1;
        if (drop && (drop_q != {DROP_WIDTH{1'b1}})) drop_q <= drop_q + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_PHY; g++) begin : g_phy
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        phy_wr_q[g]            <= 1'b0;
        phy_dat_q[16*g +: 16]  <= 16'd0;
      end else begin
        phy_wr_q[g] <= accept && (act == 2'(g));
        if (accept && (act == 2'(g))) phy_dat_q[16*g +: 16] <= src_dat_i;
      end
    end
  end

  assign phy_wr_o      = phy_wr_q;
  assign phy_dat_o     = phy_dat_q;
  assign phy_rst_o     = {NUM_PHY{in_rst}};
  assign src_rst_ack_o = (state_q == S_RST_DONE);
  assign active_o      = active_q;
  assign frame_cnt_o   = frame_q;
  assign drop_cnt_o    = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_ev2_phy_router.sv
`default_nettype none
// ============================================================================
// Module  : tb_ev2_phy_router
// Purpose : Scoreboard bench for ev2_phy_router. A FAILOVER instance is driven
//           with directed and random traffic against an event-level model;
//           a FIXED instance with a 2-bit drop counter covers the no-link and
//           saturation cases.
// Revision: 1.0  initial release
// ============================================================================
module tb_ev2_phy_router;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  always #5 clk = ~clk;

  // Main (FAILOVER) instance
  logic [15:0] src_dat_i = '0;
  logic        src_wr_i = 0, src_last_i = 0, src_rst_i = 0;
  logic [1:0]  sel_i = '0, link_up_i = '0, phy_full_i = '0, phy_rst_ack_i = '0;
  logic [31:0] phy_count_i = '0;
  logic        src_full_o, src_rst_ack_o;
  logic [15:0] src_count_o;
  logic [31:0] phy_dat_o, frame_cnt_o;
  logic [1:0]  phy_wr_o, phy_rst_o, active_o;
  logic [15:0] drop_cnt_o;

  ev2_phy_router u_dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .src_dat_i(src_dat_i), .src_wr_i(src_wr_i), .src_last_i(src_last_i),
    .src_full_o(src_full_o), .src_count_o(src_count_o),
    .src_rst_i(src_rst_i), .src_rst_ack_o(src_rst_ack_o),
    .sel_i(sel_i), .link_up_i(link_up_i),
    .phy_dat_o(phy_dat_o), .phy_wr_o(phy_wr_o), .phy_rst_o(phy_rst_o),
    .phy_full_i(phy_full_i), .phy_rst_ack_i(phy_rst_ack_i), .phy_count_i(phy_count_i),
    .active_o(active_o), .frame_cnt_o(frame_cnt_o), .drop_cnt_o(drop_cnt_o)
  );

  // Second instance: FIXED mode, 2-bit drop counter
  logic [15:0] b_dat = '0;
  logic        b_wr = 0, b_last = 0, b_src_rst = 0;
  logic [1:0]  b_sel = '0, b_link = '0, b_full = '0, b_ack = '0;
  logic [31:0] b_cnt = 32'h1234_5678;
  logic        b_src_full_o, b_src_rst_ack_o;
  logic [15:0] b_src_count_o;
  logic [31:0] b_phy_dat_o, b_frame_cnt_o;
  logic [1:0]  b_phy_wr_o, b_phy_rst_o, b_active_o, b_drop_cnt_o;

  ev2_phy_router #(.NUM_PHY(2), .MODE("FIXED"), .DROP_WIDTH(2)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n),
    .src_dat_i(b_dat), .src_wr_i(b_wr), .src_last_i(b_last),
    .src_full_o(b_src_full_o), .src_count_o(b_src_count_o),
    .src_rst_i(b_src_rst), .src_rst_ack_o(b_src_rst_ack_o),
    .sel_i(b_sel), .link_up_i(b_link),
    .phy_dat_o(b_phy_dat_o), .phy_wr_o(b_phy_wr_o), .phy_rst_o(b_phy_rst_o),
    .phy_full_i(b_full), .phy_rst_ack_i(b_ack), .phy_count_i(b_cnt),
    .active_o(b_active_o), .frame_cnt_o(b_frame_cnt_o), .drop_cnt_o(b_drop_cnt_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Scoreboard: expected forwarded words (bridge, data, cycle of appearance)
  int          q_phy[$];
  logic [15:0] q_dat[$];
  int          q_cyc[$];

  // Event-level reference model
  int          m_act    = 0;
  bit          m_in_evt = 0;
  logic [31:0] m_frames = 0;
  logic [31:0] m_drops  = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write seen on a bridge must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (phy_wr_o[i]) begin
          if (q_phy.size() == 0) begin
            chk("sb_extra_wr", 64'(q_phy.size()), 64'd1);
          end else begin
            chk("sb_phy", 64'(i), 64'(q_phy.pop_front()));
            chk("sb_dat", 64'(phy_dat_o[16*i +: 16]), 64'(q_dat.pop_front()));
            chk("sb_lat", 64'(cyc), 64'(q_cyc.pop_front()));
          end
        end
      end
      chk("b_no_wr", 64'(b_phy_wr_o), 64'd0);
    end
  end

  // Bridge choice made at an event boundary, from the selection rules.
  function automatic int choose(input int sel, input logic [1:0] link, input int cur);
    int s;
    if (link == 2'b00) return cur;
    s = (sel < 2) ? sel : 0;
    if (link[s]) return s;
    return link[0] ? 0 : 1;
  endfunction

  // One clock cycle of source traffic plus the model's view of it.
  task automatic step(input bit wr, input bit last, input logic [15:0] dat,
                      input int sel, input logic [1:0] link, input logic [1:0] full);
    bit nl, f;
    @(posedge clk); #1;
    chk("active", 64'(active_o), 64'(m_act));
    chk("frame_cnt", 64'(frame_cnt_o), 64'(m_frames));
    chk("drop_cnt", 64'(drop_cnt_o), 64'(m_drops));
    sel_i = 2'(sel); link_up_i = link; phy_full_i = full;
    src_wr_i = wr; src_last_i = last; src_dat_i = dat;
    phy_count_i = $urandom;
    if (!m_in_evt) m_act = choose(sel, link, m_act);
    nl = (link == 2'b00);
    f  = full[m_act] || nl;
    #1;
    chk("src_full", 64'(src_full_o), 64'(f));
    chk("src_count", 64'(src_count_o), nl ? 64'd0 : 64'(phy_count_i[16*m_act +: 16]));
    if (wr) begin
      if (!f) begin
        q_phy.push_back(m_act); q_dat.push_back(dat); q_cyc.push_back(cyc + 1);
        if (last) begin m_frames++; m_in_evt = 0; end
        else m_in_evt = 1;
      end else begin
        if (m_drops < 32'd65535) m_drops++;
        if (last) m_in_evt = 0;
      end
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_phy_wr", 64'(phy_wr_o), 64'd0);
    chk("rst_phy_dat", 64'(phy_dat_o), 64'd0);
    chk("rst_phy_rst", 64'(phy_rst_o), 64'd0);
    chk("rst_ack", 64'(src_rst_ack_o), 64'd0);
    chk("rst_active", 64'(active_o), 64'd0);
    chk("rst_frame", 64'(frame_cnt_o), 64'd0);
    chk("rst_drop", 64'(drop_cnt_o), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Failover away from an unlinked requested bridge
    step(0, 0, 16'h0, 1, 2'b01, 2'b00);
    for (int k = 0; k < 4; k++) step(1, k == 3, 16'(16'hA0 + k), 1, 2'b01, 2'b00);
    step(0, 0, 16'h0, 1, 2'b01, 2'b00);
    chk("failover_active", 64'(active_o), 64'd0);
    chk("failover_frames", 64'(frame_cnt_o), 64'd1);

    // Selection change mid-event takes effect only on the next event
    for (int k = 0; k < 5; k++) step(1, k == 4, 16'(16'hB0 + k), (k < 2) ? 0 : 1, 2'b11, 2'b00);
    for (int k = 0; k < 2; k++) step(1, k == 1, 16'(16'hC0 + k), 1, 2'b11, 2'b00);
    step(0, 0, 16'h0, 0, 2'b11, 2'b00);

    // Backpressure from the active bridge for three write cycles
    for (int k = 0; k < 6; k++)
      step(1, k == 5, 16'(16'hD0 + k), 0, 2'b11, (k >= 1 && k <= 3) ? 2'b01 : 2'b00);
    step(0, 0, 16'h0, 0, 2'b11, 2'b00);
    chk("backpressure_drops", 64'(drop_cnt_o), 64'd3);

    // Event-path reset mid-event; bridge 1 acknowledges four cycles late
    step(1, 0, 16'h0E00, 0, 2'b11, 2'b00);
    step(1, 0, 16'h0E01, 0, 2'b11, 2'b00);
    @(posedge clk); #1;
    src_wr_i = 0; src_rst_i = 1;
    m_in_evt = 0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      chk("srst_phy_rst", 64'(phy_rst_o), 64'h3);
      chk("srst_ack", 64'(src_rst_ack_o), 64'(n >= 6));
      chk("srst_full", 64'(src_full_o), 64'd1);
      if (n == 1) phy_rst_ack_i[0] = 1'b1;
      if (n == 5) phy_rst_ack_i[1] = 1'b1;
    end
    chk("srst_frame", 64'(frame_cnt_o), 64'd0);
    chk("srst_drop", 64'(drop_cnt_o), 64'd0);
    m_frames = 0; m_drops = 0;
    src_rst_i = 0; phy_rst_ack_i = 2'b00;
    @(posedge clk); #1;
    chk("srst_ack_fall", 64'(src_rst_ack_o), 64'd0);
    chk("srst_phy_fall", 64'(phy_rst_o), 64'd0);
    chk("srst_idle_full", 64'(src_full_o), 64'd0);

    // Random traffic: selection, link loss, backpressure, event lengths
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3, 16'($urandom),
           int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           {$urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15});
    end
    step(0, 0, 16'h0, 0, 2'b11, 2'b00);

    // FIXED instance: requested bridge has no link, drop counter saturates
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("b_drop_run", 64'(b_drop_cnt_o), (k > 3) ? 64'd3 : 64'(k));
      b_wr = 1; b_sel = 2'd1; b_dat = 16'(k);
      #1;
      chk("b_full", 64'(b_src_full_o), 64'd1);
      chk("b_count", 64'(b_src_count_o), 64'd0);
    end
    @(posedge clk); #1;
    b_wr = 0;
    chk("b_drop_sat", 64'(b_drop_cnt_o), 64'd3);
    chk("b_frame", 64'(b_frame_cnt_o), 64'd0);

    // Asynchronous reset in the middle of a streaming event
    step(1, 1, 16'h1111, 0, 2'b11, 2'b00);
    step(1, 0, 16'h2222, 0, 2'b11, 2'b00);
    @(posedge clk); #2;
    chk("pre_arst_wr", 64'(phy_wr_o), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_phy_wr", 64'(phy_wr_o), 64'd0);
    chk("arst_phy_dat", 64'(phy_dat_o), 64'd0);
    chk("arst_phy_rst", 64'(phy_rst_o), 64'd0);
    chk("arst_ack", 64'(src_rst_ack_o), 64'd0);
    chk("arst_active", 64'(active_o), 64'd0);
    chk("arst_frame", 64'(frame_cnt_o), 64'd0);
    chk("arst_drop", 64'(drop_cnt_o), 64'd0);
    chk("arst_b_drop", 64'(b_drop_cnt_o), 64'd0);
    src_wr_i = 0; src_last_i = 0;
    q_phy.delete(); q_dat.delete(); q_cyc.delete();
    m_act = 0; m_in_evt = 0; m_frames = 0; m_drops = 0;
    #1 rst_n = 1'b1;
    step(1, 1, 16'h3333, 0, 2'b11, 2'b00);
    step(0, 0, 16'h0, 0, 2'b11, 2'b00);
    step(0, 0, 16'h0, 0, 2'b11, 2'b00);
    chk("sb_leftover", 64'(q_phy.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
